// File: rtl/tremolo_pkg.sv
// rtl/tremolo_pkg.sv - shared LFO types, unity constant and period helpers for tremolo_mc
package tremolo_pkg;

    typedef enum logic [1:0] {ON, OFF, RISE, FALL} lfo_state_t;
    typedef enum logic {MODE_SQUARE, MODE_TRI} lfo_mode_t;

    localparam int TREM_CTRL_W = 8;
    localparam int UNITY       = 1 << TREM_CTRL_W;

    function automatic int total_period(int rate, int ctrl_w, int rate_shift);
        return ((1 << ctrl_w) - rate) << rate_shift;
    endfunction

    function automatic int on_period(int total, int duty, int ctrl_w);
        return (total * duty) >> ctrl_w;
    endfunction

    // Triangle takes 2*unity steps per period; never let the divider reach zero.
    function automatic int tick_div(int total, int ctrl_w);
        int t;
        t = total >> (ctrl_w + 1);
        return (t < 1) ? 1 : t;
    endfunction

endpackage

// File: rtl/tremolo_mc_if.sv
// rtl/tremolo_mc_if.sv - control, audio and gain bundle between the pedal chain and tremolo_mc
interface tremolo_mc_if #(
    parameter int DATA_W = 24,
    parameter int CTRL_W = 8,
    parameter int NUM_CH = 2
);
    import tremolo_pkg::*;

    logic                           Enable;
    lfo_mode_t                      Mode;
    logic [CTRL_W-1:0]              Rate;
    logic [CTRL_W-1:0]              Depth;
    logic [CTRL_W-1:0]              Duty_Cycle;
    logic [NUM_CH-1:0][DATA_W-1:0]  D_In;
    logic [NUM_CH-1:0][DATA_W-1:0]  D_Out;
    logic [CTRL_W:0]                Gain;

    modport master (
        output Enable, Mode, Rate, Depth, Duty_Cycle, D_In,
        input  D_Out, Gain
    );

    modport slave (
        input  Enable, Mode, Rate, Depth, Duty_Cycle, D_In,
        output D_Out, Gain
    );
endinterface

// File: rtl/trem_lfo.sv
// rtl/trem_lfo.sv - square/triangle LFO, modulation m and gain register
// TREMOLO_SLEW_EN limits the per-sample gain change to SLEW_STEP.
module trem_lfo
    import tremolo_pkg::*;
#(
    parameter int CTRL_W     = 8,
    parameter int PHASE_W    = 15,
    parameter int RATE_SHIFT = 6,
    parameter int SLEW_STEP  = 4
) (
    input  logic              Lrck,
    input  logic              Reset,
    input  logic              enable,
    input  lfo_mode_t         mode,
    input  logic [CTRL_W-1:0] rate,
    input  logic [CTRL_W-1:0] depth,
    input  logic [CTRL_W-1:0] duty,
    output logic [CTRL_W:0]   gain_now,
    output logic [CTRL_W:0]   gain
);

    localparam logic [CTRL_W:0]  M_FULL = (CTRL_W+1)'(1 << CTRL_W);
    localparam logic [CTRL_W:0]  ONE_M  = (CTRL_W+1)'(1);
    localparam logic [PHASE_W-1:0] ONE_P = PHASE_W'(1);
`ifdef TREMOLO_SLEW_EN
    localparam int STEP = SLEW_STEP;
`else
    // A step of at least full scale never limits, so the gain follows its target.
    localparam int STEP = (SLEW_STEP > (1 << CTRL_W)) ? SLEW_STEP : (1 << CTRL_W);
`endif

    lfo_state_t          state, state_n;
    logic [PHASE_W-1:0]  count, count_n;
    logic [CTRL_W:0]     m, m_n, m_use, target;
    logic [PHASE_W-1:0]  total_p, on_p, off_p, tick_p;
    logic [2*CTRL_W:0]   prod;
    int                  diff;

    always_comb begin
        total_p = PHASE_W'(total_period(int'(rate), CTRL_W, RATE_SHIFT));
        on_p    = PHASE_W'(on_period(int'(total_p), int'(duty), CTRL_W));
        off_p   = total_p - on_p;
        tick_p  = PHASE_W'(tick_div(int'(total_p), CTRL_W));
    end

    // With a zero ON period the square sits in OFF, including the edge that leaves ON.
    assign m_use = (mode == MODE_SQUARE && state == ON && on_p == '0) ? M_FULL : m;
    assign prod  = {{(CTRL_W+1){1'b0}}, depth} * {{CTRL_W{1'b0}}, m_use};
    assign target = M_FULL - (CTRL_W+1)'(prod >> CTRL_W);

    always_comb begin
        diff = int'(target) - int'(gain);
        if (diff > STEP)
            gain_now = (CTRL_W+1)'(int'(gain) + STEP);
        else if (diff < -STEP)
            gain_now = (CTRL_W+1)'(int'(gain) - STEP);
        else
            gain_now = target;
    end

    always_comb begin
        state_n = state;
        count_n = count;
        m_n     = m;
        if (!enable) begin
            state_n = (mode == MODE_TRI) ? RISE : ON;
            count_n = '0;
            m_n     = '0;
        end else begin
            case (state)
                ON, OFF: begin
                    if (mode == MODE_TRI) begin
                        state_n = RISE;
                        count_n = '0;
                    end else if (state == ON) begin
                        if (on_p == '0 || count >= on_p - ONE_P) begin
                            state_n = OFF;
                            count_n = '0;
                            m_n     = M_FULL;
                        end else begin
                            count_n = count + ONE_P;
                            m_n     = '0;
                        end
                    end else begin
                        if (count >= off_p - ONE_P) begin
                            state_n = ON;
                            count_n = '0;
                            m_n     = '0;
                        end else begin
                            count_n = count + ONE_P;
                            m_n     = M_FULL;
                        end
                    end
                end
                RISE, FALL: begin
                    if (mode == MODE_SQUARE) begin
                        state_n = ON;
                        count_n = '0;
                    end else if (count >= tick_p - ONE_P) begin
                        count_n = '0;
                        if (state == RISE) begin
                            if (m >= M_FULL) begin
                                m_n     = m - ONE_M;
                                state_n = FALL;
                            end else begin
                                m_n = m + ONE_M;
                                if (m + ONE_M == M_FULL)
                                    state_n = FALL;
                            end
                        end else begin
                            if (m == '0) begin
                                m_n     = ONE_M;
                                state_n = RISE;
                            end else begin
                                m_n = m - ONE_M;
                                if (m == ONE_M)
                                    state_n = RISE;
                            end
                        end
                    end else begin
                        count_n = count + ONE_P;
                    end
                end
                default: begin
                    state_n = ON;
                    count_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Lrck or posedge Reset) begin
        if (Reset) begin
            state <= ON;
            count <= '0;
            m     <= '0;
            gain  <= M_FULL;
        end else begin
            state <= state_n;
            count <= count_n;
            m     <= m_n;
            gain  <= enable ? gain_now : M_FULL;
        end
    end

endmodule

// File: rtl/tremolo_mc.sv
// rtl/tremolo_mc.sv - multi-channel tremolo: one shared LFO gain applied to NUM_CH samples
// Gain slewing is selected with TREMOLO_SLEW_EN inside trem_lfo.
module tremolo_mc
    import tremolo_pkg::*;
#(
    parameter int DATA_W     = 24,
    parameter int CTRL_W     = 8,
    parameter int NUM_CH     = 2,
    parameter int PHASE_W    = 15,
    parameter int RATE_SHIFT = 6,
    parameter int SLEW_STEP  = 4
) (
    input  logic       Lrck,
    input  logic       Reset,
    tremolo_mc_if.slave bus
);

    localparam int PW = DATA_W + CTRL_W + 2;

    logic [CTRL_W:0]               gain_now;
    logic [CTRL_W:0]               gain;
    logic [NUM_CH-1:0][DATA_W-1:0] d_out_q;

    trem_lfo #(
        .CTRL_W    (CTRL_W),
        .PHASE_W   (PHASE_W),
        .RATE_SHIFT(RATE_SHIFT),
        .SLEW_STEP (SLEW_STEP)
    ) u_lfo (
        .Lrck    (Lrck),
        .Reset   (Reset),
        .enable  (bus.Enable),
        .mode    (bus.Mode),
        .rate    (bus.Rate),
        .depth   (bus.Depth),
        .duty    (bus.Duty_Cycle),
        .gain_now(gain_now),
        .gain    (gain)
    );

    // The sample leaving on this edge uses the same gain that Gain reports afterwards.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic signed [PW-1:0] samp_x, gain_x, prod;
        logic [DATA_W-1:0]    scaled;

        assign samp_x = PW'($signed(bus.D_In[ch]));
        assign gain_x = PW'({1'b0, gain_now});
        assign prod   = samp_x * gain_x;
        assign scaled = DATA_W'(prod >>> CTRL_W);

        always_ff @(posedge Lrck or posedge Reset) begin
            if (Reset)
                d_out_q[ch] <= '0;
            else if (bus.Enable)
                d_out_q[ch] <= scaled;
            else
                d_out_q[ch] <= bus.D_In[ch];
        end
    end

    assign bus.D_Out = d_out_q;
    assign bus.Gain  = gain;

endmodule
